// File: rtl/network_tx_arb.sv
// Round-robin, credit-gated arbiter that funnels per-channel request packets into one
// registered network slot and demuxes returned responses back to their channels.
module network_tx_arb #(
    parameter int num_chan_p        = 2,
    parameter int packet_width_p    = 128,
    parameter int data_width_p      = 32,
    parameter int max_out_credits_p = 16,
    localparam int chan_id_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
    localparam int credit_width_lp  = $clog2(max_out_credits_p + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic [num_chan_p-1:0]                req_v_i,
    input  logic [num_chan_p*packet_width_p-1:0] req_packet_i,
    input  logic [num_chan_p-1:0]                req_invalid_i,
    output logic [num_chan_p-1:0]                req_yumi_o,

    output logic [packet_width_p-1:0]            out_packet_o,
    output logic                                 out_v_o,
    input  logic                                 out_ready_i,

    input  logic                                 credit_v_i,

    input  logic                                 returned_v_i,
    input  logic [data_width_p-1:0]              returned_data_i,
    input  logic [chan_id_width_lp-1:0]          returned_chan_i,
    output logic                                 returned_yumi_o,

    output logic [num_chan_p-1:0]                resp_v_o,
    output logic [data_width_p-1:0]              resp_data_o,
    input  logic [num_chan_p-1:0]                resp_yumi_i,

    output logic [credit_width_lp-1:0]           credits_o,
    output logic                                 out_credits_empty_o,
    output logic [num_chan_p-1:0]                invalid_access_o
);

    localparam logic [credit_width_lp-1:0] cred_max_lp = credit_width_lp'(max_out_credits_p);

    typedef struct packed {
        logic                      v;
        logic [packet_width_p-1:0] packet;
    } slot_t;

    logic [num_chan_p-1:0][packet_width_p-1:0] pkts;
    logic [num_chan_p-1:0]        elig;
    logic [num_chan_p-1:0]        bad_req;
    logic [num_chan_p-1:0]        grant_oh;
    logic [num_chan_p-1:0]        hit;
    logic [chan_id_width_lp-1:0]  ptr;
    logic [chan_id_width_lp-1:0]  grant_id;
    logic [credit_width_lp-1:0]   credits;
    logic                         found;
    logic                         grant;
    logic                         slot_free;
    logic                         chan_ok;
    int                           idx;
    slot_t                        slot;

    assign pkts      = req_packet_i;
    assign bad_req   = req_v_i & req_invalid_i;
    assign elig      = req_v_i & ~req_invalid_i;
    assign slot_free = ~slot.v | out_ready_i;

    // Search begins at ptr, which always names the highest-priority channel.
    always_comb begin
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        for (int i = 0; i < num_chan_p; i++) begin
            idx = int'(ptr) + i;
            if (idx >= num_chan_p) idx = idx - num_chan_p;
            if (!found && elig[idx]) begin
                found    = 1'b1;
                grant_id = chan_id_width_lp'(idx);
            end
        end
    end

    assign grant = found && (credits != '0) && slot_free && !reset_i;

    always_comb begin
        grant_oh = '0;
        grant_oh[grant_id] = grant;
    end

    assign req_yumi_o       = reset_i ? '0 : (bad_req | grant_oh);
    assign invalid_access_o = reset_i ? '0 : bad_req;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr <= '0;
        end else if (grant) begin
            ptr <= (grant_id == chan_id_width_lp'(num_chan_p - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // A grant refills the slot even while it is draining, giving one packet per cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            slot <= '0;
        end else if (grant) begin
            slot.v      <= 1'b1;
            slot.packet <= pkts[grant_id];
        end else if (out_ready_i) begin
            slot.v <= 1'b0;
        end
    end

    assign out_v_o      = slot.v;
    assign out_packet_o = slot.packet;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            credits <= cred_max_lp;
        end else begin
            case ({grant, credit_v_i})
                2'b10:   credits <= credits - 1'b1;
                2'b01:   if (credits != cred_max_lp) credits <= credits + 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    assign credits_o           = credits;
    assign out_credits_empty_o = (credits == '0);

    for (genvar k = 0; k < num_chan_p; k++) begin : g_chan
        assign hit[k] = (returned_chan_i == chan_id_width_lp'(k));
    end

    assign chan_ok         = |hit;
    assign resp_v_o        = reset_i ? '0 : (hit & {num_chan_p{returned_v_i}});
    assign resp_data_o     = returned_data_i;
    // Out-of-range channel ids are swallowed so the return path cannot wedge.
    assign returned_yumi_o = chan_ok ? |(hit & resp_yumi_i) : returned_v_i;

    a_credit_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !(credit_v_i && !grant && credits == cred_max_lp))
        else $error("network_tx_arb: credit returned with counter already full");

    a_bad_resp_chan: assert property (@(posedge clk_i) disable iff (reset_i)
        !(returned_v_i && !chan_ok))
        else $error("network_tx_arb: response for nonexistent channel dropped");

endmodule

// File: tb/tb_network_tx_arb.sv
// Directed scenarios plus a randomized run against a cycle-level reference model
// for the network transmit arbiter (2 channels, 4 credits).
module tb_network_tx_arb;
    localparam int NC = 2;
    localparam int PW = 64;
    localparam int DW = 32;
    localparam int MC = 4;

    logic             clk_i = 1'b0;
    logic             reset_i;
    logic [NC-1:0]    req_v_i, req_invalid_i, req_yumi_o;
    logic [NC*PW-1:0] req_packet_i;
    logic [PW-1:0]    out_packet_o;
    logic             out_v_o, out_ready_i, credit_v_i;
    logic             returned_v_i, returned_yumi_o;
    logic [DW-1:0]    returned_data_i, resp_data_o;
    logic [0:0]       returned_chan_i;
    logic [NC-1:0]    resp_v_o, resp_yumi_i, invalid_access_o;
    logic [2:0]       credits_o;
    logic             out_credits_empty_o;

    int checks = 0;
    int errors = 0;

    network_tx_arb #(.num_chan_p(NC), .packet_width_p(PW), .data_width_p(DW),
                     .max_out_credits_p(MC)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_packet_i(req_packet_i), .req_invalid_i(req_invalid_i),
        .req_yumi_o(req_yumi_o),
        .out_packet_o(out_packet_o), .out_v_o(out_v_o), .out_ready_i(out_ready_i),
        .credit_v_i(credit_v_i),
        .returned_v_i(returned_v_i), .returned_data_i(returned_data_i),
        .returned_chan_i(returned_chan_i), .returned_yumi_o(returned_yumi_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .credits_o(credits_o), .out_credits_empty_o(out_credits_empty_o),
        .invalid_access_o(invalid_access_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [PW-1:0] mkpkt(int ch, int n);
        return {32'(ch + 1), 32'(n)};
    endfunction

    task automatic next_cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic give_credits(int n);
        credit_v_i = 1'b1;
        repeat (n) next_cycle();
        credit_v_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; req_v_i = 2'b11; req_invalid_i = 2'b11; req_packet_i = '0;
        out_ready_i = 1'b1; credit_v_i = 1'b0; returned_v_i = 1'b1; returned_chan_i = 1'b1;
        returned_data_i = '0; resp_yumi_i = '0;
        @(negedge clk_i); #1;
        checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL reset_out_v got %0b exp 0", out_v_o); end
        checks++; if (out_packet_o !== '0) begin errors++; $display("FAIL reset_out_packet got %h exp 0", out_packet_o); end
        checks++; if (credits_o !== 3'(MC)) begin errors++; $display("FAIL reset_credits got %0d exp %0d", credits_o, MC); end
        checks++; if (out_credits_empty_o !== 1'b0) begin errors++; $display("FAIL reset_empty got %0b exp 0", out_credits_empty_o); end
        checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL reset_req_yumi got %b exp 00", req_yumi_o); end
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL reset_resp_v got %b exp 00", resp_v_o); end
        reset_i = 1'b0; req_v_i = '0; req_invalid_i = '0; returned_v_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_arbitration();
        logic [1:0] exp;
        req_v_i = 2'b11; out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_packet_i = {mkpkt(1, i), mkpkt(0, i)}; #1;
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (req_yumi_o !== exp) begin errors++; $display("FAIL arb_grant[%0d] got %b exp %b", i, req_yumi_o, exp); end
            if (i > 0) begin
                checks++; if (out_v_o !== 1'b1 || out_packet_o !== mkpkt((i - 1) % 2, i - 1)) begin
                    errors++; $display("FAIL arb_out[%0d] got v=%0b %h exp v=1 %h", i, out_v_o, out_packet_o, mkpkt((i - 1) % 2, i - 1)); end
                checks++; if (credits_o !== 3'(MC - i)) begin errors++; $display("FAIL arb_credits[%0d] got %0d exp %0d", i, credits_o, MC - i); end
            end
            next_cycle();
        end
        #1;
        checks++; if (out_packet_o !== mkpkt(1, 3)) begin errors++; $display("FAIL arb_last_pkt got %h exp %h", out_packet_o, mkpkt(1, 3)); end
        checks++; if (credits_o !== 3'd0 || out_credits_empty_o !== 1'b1) begin
            errors++; $display("FAIL arb_empty got credits=%0d empty=%0b exp 0 1", credits_o, out_credits_empty_o); end
        checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL arb_stall got %b exp 00", req_yumi_o); end
        req_v_i = '0;
        next_cycle(); #1;
        checks++; if (out_v_o !== 1'b0) begin errors++; $display("FAIL arb_drain got %0b exp 0", out_v_o); end
        give_credits(MC);
    endtask

    task automatic test_credit_exhaustion();
        int sent = 0;
        req_v_i = 2'b01; out_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_packet_i = {mkpkt(1, 0), mkpkt(0, sent)}; #1;
            if (i >= 4) begin
                checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL cx_stall[%0d] got %b exp 00", i, req_yumi_o); end
            end
            if (req_yumi_o[0]) sent++;
            next_cycle();
        end
        #1;
        checks++; if (sent !== 4) begin errors++; $display("FAIL cx_sent got %0d exp 4", sent); end
        checks++; if (out_credits_empty_o !== 1'b1) begin errors++; $display("FAIL cx_empty got %0b exp 1", out_credits_empty_o); end
        credit_v_i = 1'b1; req_packet_i = {mkpkt(1, 0), mkpkt(0, 4)}; #1;
        checks++; if (req_yumi_o !== 2'b00) begin errors++; $display("FAIL cx_pulse1 got %b exp 00", req_yumi_o); end
        next_cycle(); #1;
        checks++; if (req_yumi_o !== 2'b01) begin errors++; $display("FAIL cx_pulse2 got %b exp 01", req_yumi_o); end
        next_cycle();
        credit_v_i = 1'b0; req_packet_i = {mkpkt(1, 0), mkpkt(0, 5)}; #1;
        checks++; if (req_yumi_o !== 2'b01 || credits_o !== 3'd1) begin
            errors++; $display("FAIL cx_resend got yumi=%b credits=%0d exp 01 1", req_yumi_o, credits_o); end
        checks++; if (out_packet_o !== mkpkt(0, 4)) begin errors++; $display("FAIL cx_pkt5 got %h exp %h", out_packet_o, mkpkt(0, 4)); end
        next_cycle();
        req_v_i = '0; #1;
        checks++; if (out_packet_o !== mkpkt(0, 5) || credits_o !== 3'd0) begin
            errors++; $display("FAIL cx_pkt6 got %h credits=%0d exp %h 0", out_packet_o, credits_o, mkpkt(0, 5)); end
        next_cycle();
        give_credits(MC);
    endtask

    task automatic test_backpressure();
        req_v_i = 2'b10; out_ready_i = 1'b0; req_packet_i = {mkpkt(1, 100), mkpkt(0, 0)}; #1;
        checks++; if (req_yumi_o !== 2'b10) begin errors++; $display("FAIL bp_first got %b exp 10", req_yumi_o); end
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            req_packet_i = {mkpkt(1, 101 + i), mkpkt(0, 0)}; #1;
            checks++; if (req_yumi_o !== 2'b00 || out_v_o !== 1'b1 || out_packet_o !== mkpkt(1, 100) || credits_o !== 3'(MC - 1)) begin
                errors++; $display("FAIL bp_hold[%0d] got yumi=%b v=%0b %h credits=%0d exp 00 1 %h %0d",
                                   i, req_yumi_o, out_v_o, out_packet_o, credits_o, mkpkt(1, 100), MC - 1); end
            next_cycle();
        end
        out_ready_i = 1'b1; req_packet_i = {mkpkt(1, 200), mkpkt(0, 0)}; #1;
        checks++; if (req_yumi_o !== 2'b10) begin errors++; $display("FAIL bp_release got %b exp 10", req_yumi_o); end
        next_cycle();
        req_v_i = '0; #1;
        checks++; if (out_packet_o !== mkpkt(1, 200) || credits_o !== 3'(MC - 2)) begin
            errors++; $display("FAIL bp_next got %h credits=%0d exp %h %0d", out_packet_o, credits_o, mkpkt(1, 200), MC - 2); end
        next_cycle();
        give_credits(2);
    endtask

    task automatic test_invalid();
        req_v_i = 2'b11; req_invalid_i = 2'b01; req_packet_i = {mkpkt(1, 300), mkpkt(0, 301)}; #1;
        checks++; if (req_yumi_o !== 2'b11) begin errors++; $display("FAIL inv_yumi got %b exp 11", req_yumi_o); end
        checks++; if (invalid_access_o !== 2'b01) begin errors++; $display("FAIL inv_access got %b exp 01", invalid_access_o); end
        next_cycle();
        req_v_i = '0; req_invalid_i = '0; #1;
        checks++; if (out_v_o !== 1'b1 || out_packet_o !== mkpkt(1, 300) || credits_o !== 3'(MC - 1)) begin
            errors++; $display("FAIL inv_sent got v=%0b %h credits=%0d exp 1 %h %0d", out_v_o, out_packet_o, credits_o, mkpkt(1, 300), MC - 1); end
        next_cycle();
        give_credits(1);
    endtask

    task automatic test_responses();
        logic [DW-1:0] d;
        returned_v_i = 1'b1; returned_chan_i = 1'b1; resp_yumi_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            d = $urandom; returned_data_i = d;
            if (i == 2) resp_yumi_i = 2'b10;
            #1;
            checks++; if (resp_v_o !== 2'b10 || resp_data_o !== d || returned_yumi_o !== (i == 2)) begin
                errors++; $display("FAIL resp[%0d] got v=%b d=%h yumi=%0b exp 10 %h %0b", i, resp_v_o, resp_data_o, returned_yumi_o, d, i == 2); end
            next_cycle();
        end
        returned_chan_i = 1'b0; resp_yumi_i = 2'b10; #1;
        checks++; if (resp_v_o !== 2'b01 || returned_yumi_o !== 1'b0) begin
            errors++; $display("FAIL resp_ch0_wrongyumi got v=%b yumi=%0b exp 01 0", resp_v_o, returned_yumi_o); end
        resp_yumi_i = 2'b01; #1;
        checks++; if (returned_yumi_o !== 1'b1) begin errors++; $display("FAIL resp_ch0_yumi got %0b exp 1", returned_yumi_o); end
        returned_v_i = 1'b0; resp_yumi_i = '0; #1;
        checks++; if (resp_v_o !== 2'b00) begin errors++; $display("FAIL resp_idle got %b exp 00", resp_v_o); end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        req_v_i = 2'b01; out_ready_i = 1'b1; req_packet_i = {mkpkt(1, 0), mkpkt(0, 400)};
        repeat (MC - 1) next_cycle();
        credit_v_i = 1'b1; #1;
        checks++; if (credits_o !== 3'd1 || req_yumi_o !== 2'b01) begin
            errors++; $display("FAIL sim_pre got credits=%0d yumi=%b exp 1 01", credits_o, req_yumi_o); end
        next_cycle();
        credit_v_i = 1'b0; req_v_i = '0; #1;
        checks++; if (credits_o !== 3'd1 || out_v_o !== 1'b1) begin
            errors++; $display("FAIL sim_credit got credits=%0d v=%0b exp 1 1", credits_o, out_v_o); end
        #2 reset_i = 1'b1;
        #1;
        checks++; if (out_v_o !== 1'b0 || credits_o !== 3'(MC) || out_packet_o !== '0) begin
            errors++; $display("FAIL async_reset got v=%0b credits=%0d pkt=%h exp 0 %0d 0", out_v_o, credits_o, out_packet_o, MC); end
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic test_random();
        int m_ptr = 0, m_cred = MC, g, c;
        logic m_v = 1'b0;
        logic [PW-1:0] m_pkt = '0, p0, p1;
        logic [1:0] rv, inv, elig, exp_yumi, ry, exp_rv;
        logic ready, cv, retv, rch;
        logic [DW-1:0] rd;
        for (int n = 0; n < 400; n++) begin
            rv = 2'($urandom_range(0, 3));
            inv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            p0 = {$urandom, $urandom}; p1 = {$urandom, $urandom};
            ready = ($urandom_range(0, 3) != 0);
            cv = (m_cred < MC) && ($urandom_range(0, 2) == 0);
            retv = 1'($urandom_range(0, 1)); rch = 1'($urandom_range(0, 1));
            rd = $urandom; ry = 2'($urandom_range(0, 3));
            req_v_i = rv; req_invalid_i = inv; req_packet_i = {p1, p0}; out_ready_i = ready;
            credit_v_i = cv; returned_v_i = retv; returned_chan_i = rch; returned_data_i = rd; resp_yumi_i = ry;
            #1;
            elig = rv & ~inv; g = -1;
            if (elig != 0 && m_cred > 0 && (!m_v || ready))
                for (int k = 0; k < NC; k++) begin
                    c = (m_ptr + k) % NC;
                    if (g < 0 && elig[c]) g = c;
                end
            exp_yumi = rv & inv;
            if (g >= 0) exp_yumi[g] = 1'b1;
            exp_rv = '0;
            if (retv) exp_rv[rch] = 1'b1;
            checks++; if (out_v_o !== m_v || out_packet_o !== m_pkt) begin
                errors++; $display("FAIL rnd_out[%0d] got v=%0b %h exp v=%0b %h", n, out_v_o, out_packet_o, m_v, m_pkt); end
            checks++; if (credits_o !== 3'(m_cred) || out_credits_empty_o !== (m_cred == 0)) begin
                errors++; $display("FAIL rnd_credits[%0d] got %0d/%0b exp %0d", n, credits_o, out_credits_empty_o, m_cred); end
            checks++; if (req_yumi_o !== exp_yumi || invalid_access_o !== (rv & inv)) begin
                errors++; $display("FAIL rnd_yumi[%0d] got %b/%b exp %b/%b", n, req_yumi_o, invalid_access_o, exp_yumi, rv & inv); end
            checks++; if (resp_v_o !== exp_rv || resp_data_o !== rd || returned_yumi_o !== ry[rch]) begin
                errors++; $display("FAIL rnd_resp[%0d] got %b %h %0b exp %b %h %0b", n, resp_v_o, resp_data_o, returned_yumi_o, exp_rv, rd, ry[rch]); end
            if (g >= 0) begin
                m_v = 1'b1; m_pkt = (g == 1) ? p1 : p0; m_ptr = (g + 1) % NC;
            end else if (ready) begin
                m_v = 1'b0;
            end
            m_cred = m_cred + int'(cv) - ((g >= 0) ? 1 : 0);
            next_cycle();
        end
        req_v_i = '0; credit_v_i = 1'b0; returned_v_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_credit_exhaustion();
        test_backpressure();
        test_invalid();
        test_responses();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
